// File: rtl/fp_mul_writeback.sv
// Writeback stage behind the FP multiplier: derives IEEE exception flags,
// canonicalises invalid results, buffers two entries and accumulates sticky fflags.
module fp_mul_writeback #(
    parameter int BUS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_result,
    input  logic [BUS_WIDTH-1:0] in_op1,
    input  logic [BUS_WIDTH-1:0] in_op2,
    input  logic [4:0]           in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_result,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_flags,
    input  logic                 flush,
    input  logic                 fflags_clr,
    output logic [4:0]           fflags
);
    localparam int EXP_W = (BUS_WIDTH == 32) ? 8 : 11;
    localparam int MAN_W = BUS_WIDTH - 1 - EXP_W;
    localparam logic [BUS_WIDTH-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
        logic finite;
    } op_class_t;

    function automatic op_class_t classify(input logic [BUS_WIDTH-1:0] op);
        op_class_t c;
        logic      exp_ones;
        logic      man_zero;
        exp_ones = &op[BUS_WIDTH-2 -: EXP_W];
        man_zero = ~|op[MAN_W-1:0];
        c.nan    = exp_ones & ~man_zero;
        c.snan   = exp_ones & ~man_zero & ~op[MAN_W-1];
        c.inf    = exp_ones & man_zero;
        c.zero   = ~|op[BUS_WIDTH-2:0];
        c.finite = ~exp_ones;
        return c;
    endfunction

    op_class_t            cls1;
    op_class_t            cls2;
    logic                 res_inf;
    logic                 res_zero;
    logic                 flag_nv;
    logic                 flag_of;
    logic                 flag_uf;
    logic [4:0]           new_flags;
    logic [BUS_WIDTH-1:0] new_result;

    // Flags are {NV, DZ, OF, UF, NX}; a multiplier never raises DZ, and NX is not tracked here.
    always_comb begin
        cls1       = classify(in_op1);
        cls2       = classify(in_op2);
        res_inf    = (&in_result[BUS_WIDTH-2 -: EXP_W]) & ~|in_result[MAN_W-1:0];
        res_zero   = ~|in_result[BUS_WIDTH-2:0];
        flag_nv    = cls1.snan | cls2.snan | (cls1.inf & cls2.zero) | (cls2.inf & cls1.zero);
        flag_of    = res_inf & cls1.finite & cls2.finite;
        flag_uf    = res_zero & cls1.finite & cls2.finite & ~cls1.zero & ~cls2.zero;
        new_flags  = {flag_nv, 1'b0, flag_of, flag_uf, 1'b0};
        new_result = (flag_nv | cls1.nan | cls2.nan) ? CANON_NAN : in_result;
    end

    logic [BUS_WIDTH-1:0] result_q [2];
    logic [4:0]           rd_q     [2];
    logic [4:0]           flags_q  [2];
    logic                 head_q;
    logic [1:0]           count_q;
    logic                 tail;
    logic                 accept;
    logic                 drain;

    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign accept     = in_valid & in_ready;
    assign drain      = out_valid & out_ready;
    assign tail       = head_q ^ count_q[0];
    assign out_result = result_q[head_q];
    assign out_rd     = rd_q[head_q];
    assign out_flags  = flags_q[head_q];

    // With one entry held, a simultaneous accept/drain writes the free slot that becomes the new head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
                rd_q[i]     <= '0;
                flags_q[i]  <= '0;
            end
        end else begin
            if (accept && !flush) begin
                result_q[tail] <= new_result;
                rd_q[tail]     <= in_rd;
                flags_q[tail]  <= new_flags;
            end
            if (drain) begin
                head_q <= ~head_q;
            end
            if (flush) begin
                count_q <= 2'd0;
            end else begin
                case ({accept, drain})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Clear takes priority over the old value but not over a same-cycle drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fflags <= 5'd0;
        end else if (fflags_clr) begin
            fflags <= drain ? out_flags : 5'd0;
        end else if (drain) begin
            fflags <= fflags | out_flags;
        end
    end

endmodule
